// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: memory request/response, decoder redirect and instruction buffer head.
// master = fetch unit, slave = memory/decoder side.
interface fetch_unit_if;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic        mem_rsp_valid;
    logic        mem_rsp_error;
    logic [31:0] mem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_pc;
    logic [31:0] inst_data;
    logic        inst_error;

    modport master (
        output mem_valid, mem_addr, inst_valid, inst_pc, inst_data, inst_error,
        input  mem_ready, mem_rsp_valid, mem_rsp_error, mem_rsp_data,
               redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  mem_valid, mem_addr, inst_valid, inst_pc, inst_data, inst_error,
        output mem_ready, mem_rsp_valid, mem_rsp_error, mem_rsp_data,
               redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: sequential PCs, accept at t -> response t+1 -> decoder sees it at t+2.
// Issue stalls while in-flight + buffered reaches FIFO_DEPTH; responses are never backpressured.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t        r_state;
    logic [31:0]   r_pc;
    logic [31:0]   r_head_pc;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_inflight;
    logic [CW-1:0] r_drop;
    logic [31:0]   r_dat [FIFO_DEPTH];
    logic          r_err [FIFO_DEPTH];

    logic [CW:0]   w_occ;
    logic          w_redirect;
    logic [31:0]   w_redirect_pc;
    logic          w_issue;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_rsp_cnt;

    assign w_redirect    = bus.redirect_valid;
    assign w_redirect_pc = {bus.redirect_pc[31:2], 2'b00};
    assign w_occ         = {1'b0, r_inflight} + {1'b0, r_count};
    assign w_issue       = (r_state == RUN) && !w_redirect && (w_occ < (CW+1)'(FIFO_DEPTH));
    assign w_accept      = w_issue && bus.mem_ready;
    // Responses still owed to a pre-redirect request are swallowed while r_drop is non-zero.
    assign w_push        = bus.mem_rsp_valid && !w_redirect && (r_drop == '0);
    assign w_pop         = (r_count != '0) && bus.inst_ready && !w_redirect;
    assign w_rsp_cnt     = CW'(bus.mem_rsp_valid);

    assign bus.mem_valid  = w_issue;
    assign bus.mem_addr   = r_pc;
    assign bus.inst_valid = (r_count != '0);
    assign bus.inst_pc    = r_head_pc;
    assign bus.inst_data  = r_dat[r_rd_ptr];
    assign bus.inst_error = r_err[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_head_pc  <= RESET_PC;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= '0;
            r_drop     <= '0;
        end else if (w_redirect) begin
            r_state    <= RUN;
            r_pc       <= w_redirect_pc;
            r_head_pc  <= w_redirect_pc;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= r_inflight - w_rsp_cnt;
            r_drop     <= r_inflight - w_rsp_cnt;
        end else begin
            case (r_state)
                IDLE:    r_state <= RUN;
                RUN:     if (w_push && bus.mem_rsp_error) r_state <= HALT;
                default: r_state <= r_state;
            endcase
            if (w_accept) begin
                r_pc <= r_pc + 32'd4;
            end
            r_inflight <= r_inflight + CW'(w_accept) - w_rsp_cnt;
            if (bus.mem_rsp_valid && (r_drop != '0)) begin
                r_drop <= r_drop - CW'(1);
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + AW'(1);
                r_head_pc <= r_head_pc + 32'd4;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_dat[r_wr_ptr] <= bus.mem_rsp_data;
            r_err[r_wr_ptr] <= bus.mem_rsp_error;
        end
    end
endmodule
